// File: rtl/rename_ctrl_pkg.sv
// Shared types and constants for the rename write-port controller.
// Build option: RENAME_ZERO_REG_EN keeps x0 out of renaming and recovery.
package rename_ctrl_pkg;

  localparam int TAG_W = 7;
  localparam int NUM_ARCH_REGS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RESTORE,
    DONE
  } rename_state_e;

`ifdef RENAME_ZERO_REG_EN
  localparam int WALK_START = 1;
`else
  localparam int WALK_START = 0;
`endif

endpackage

// File: rtl/rename_ctrl_walker.sv
// Recovery walker: FSM plus the index counter that replays the arch map.
// Build option: RENAME_ZERO_REG_EN starts the walk at index 1.
module rename_ctrl_walker
  import rename_ctrl_pkg::*;
#(
  parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
  localparam int CW = $clog2(NUM_ARCH_REGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rollback,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] idx
);

  localparam logic [CW-1:0] FIRST = CW'(WALK_START);
  localparam logic [CW-1:0] LAST = CW'(NUM_ARCH_REGS - 1);

  rename_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A rollback in any state restarts the walk from the first index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rollback) begin
      state_d = RESTORE;
      cnt_d   = FIRST;
    end else begin
      case (state_q)
        IDLE: ;
        RESTORE: begin
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == RESTORE);
    done = (state_q == DONE);
    idx  = busy ? cnt_q : '0;
  end

endmodule

// File: rtl/rename_ctrl.sv
// Map-table write-port arbiter between dispatch renaming and recovery.
// Build option: RENAME_ZERO_REG_EN makes dest x0 bypass the free list.
module rename_ctrl
  import rename_ctrl_pkg::*;
#(
  parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
  localparam int CW = $clog2(NUM_ARCH_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  logic [CW-1:0]    dest_idx,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  input  logic             rollback,
  input  logic [TAG_W-1:0] arch_tag,
  output logic             dispatch_ready,
  output logic             free_pop,
  output logic [CW-1:0]    arch_read_idx,
  output logic             mt_write_en,
  output logic [CW-1:0]    mt_write_idx,
  output logic [TAG_W-1:0] mt_write_tag,
  output logic             recover_busy,
  output logic             recover_done
);

  logic          walk_busy;
  logic          walk_done;
  logic [CW-1:0] walk_idx;
  logic          zero_dst;
  logic          rename_go;

  rename_ctrl_walker #(
    .NUM_ARCH_REGS(NUM_ARCH_REGS)
  ) u_walker (
    .clock   (clock),
    .reset   (reset),
    .rollback(rollback),
    .busy    (walk_busy),
    .done    (walk_done),
    .idx     (walk_idx)
  );

`ifdef RENAME_ZERO_REG_EN
  assign zero_dst = (dest_idx == '0);
`else
  assign zero_dst = 1'b0;
`endif

  always_comb begin
    dispatch_ready = 1'b0;
    free_pop       = 1'b0;
    arch_read_idx  = '0;
    mt_write_en    = 1'b0;
    mt_write_idx   = '0;
    mt_write_tag   = '0;
    recover_busy   = 1'b0;
    recover_done   = 1'b0;
    rename_go      = 1'b0;
    if (!reset) begin
      arch_read_idx = walk_idx;
      recover_busy  = walk_busy;
      if (rollback) begin
        // squash: nothing reaches the map table or free list
      end else if (walk_busy) begin
        mt_write_en  = 1'b1;
        mt_write_idx = walk_idx;
        mt_write_tag = arch_tag;
      end else if (walk_done) begin
        recover_done = 1'b1;
      end else begin
        dispatch_ready = free_valid || zero_dst;
        rename_go      = dispatch_valid && dispatch_ready && !zero_dst;
        mt_write_en    = rename_go;
        mt_write_idx   = rename_go ? dest_idx : '0;
        mt_write_tag   = rename_go ? free_tag : '0;
        free_pop       = rename_go;
      end
    end
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl: vector table plus recovery sequences.
// Build option: RENAME_ZERO_REG_EN changes x0 expectations and walk start.
module tb_rename_ctrl;
  import rename_ctrl_pkg::*;

  localparam int N = 32;

`ifdef RENAME_ZERO_REG_EN
  localparam int START = 1;
  localparam bit ZR = 1'b1;
`else
  localparam int START = 0;
  localparam bit ZR = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic             dispatch_valid;
  logic [4:0]       dest_idx;
  logic             free_valid;
  logic [TAG_W-1:0] free_tag;
  logic             rollback;
  logic [TAG_W-1:0] arch_tag;
  logic             dispatch_ready;
  logic             free_pop;
  logic [4:0]       arch_read_idx;
  logic             mt_write_en;
  logic [4:0]       mt_write_idx;
  logic [TAG_W-1:0] mt_write_tag;
  logic             recover_busy;
  logic             recover_done;

  int vecs = 0;
  int miss = 0;

  rename_ctrl #(.NUM_ARCH_REGS(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .dispatch_valid(dispatch_valid),
    .dest_idx      (dest_idx),
    .free_valid    (free_valid),
    .free_tag      (free_tag),
    .rollback      (rollback),
    .arch_tag      (arch_tag),
    .dispatch_ready(dispatch_ready),
    .free_pop      (free_pop),
    .arch_read_idx (arch_read_idx),
    .mt_write_en   (mt_write_en),
    .mt_write_idx  (mt_write_idx),
    .mt_write_tag  (mt_write_tag),
    .recover_busy  (recover_busy),
    .recover_done  (recover_done)
  );

  // architectural map model: entry i holds tag i+64
  assign arch_tag = TAG_W'(32'(arch_read_idx) + 64);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       dv;
    logic [4:0] idx;
    logic       fv;
    logic [6:0] tag;
    logic       rdy;
    logic       wen;
    logic [4:0] widx;
    logic [6:0] wtag;
    logic       pop;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, 32'(dispatch_ready), 0);
    chk({nm, "_wen"}, 32'(mt_write_en), 0);
    chk({nm, "_pop"}, 32'(free_pop), 0);
    chk({nm, "_busy"}, 32'(recover_busy), 0);
    chk({nm, "_done"}, 32'(recover_done), 0);
  endtask

  int busy_cyc;
  int dones;

  initial begin
    tbl[0] = '{1, 5, 1, 40, 1, 1, 5, 40, 1};
    tbl[1] = '{1, 7, 0, 3, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 9, 1, 12, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 31, 1, 127, 1, 1, 31, 127, 1};
    if (ZR) begin
      tbl[4] = '{1, 0, 1, 17, 1, 0, 0, 0, 0};
      tbl[5] = '{1, 0, 0, 2, 1, 0, 0, 0, 0};
    end else begin
      tbl[4] = '{1, 0, 1, 17, 1, 1, 0, 17, 1};
      tbl[5] = '{1, 0, 0, 2, 0, 0, 0, 0, 0};
    end

    reset = 1'b1;
    rollback = 1'b0;
    dispatch_valid = 1'b1;
    dest_idx = 5'd5;
    free_valid = 1'b1;
    free_tag = 7'd40;
    #2;
    chk_zero("reset");
    chk("reset_ard", 32'(arch_read_idx), 0);
    step();
    step();
    reset = 1'b0;
    dispatch_valid = 1'b0;
    #1;

    foreach (tbl[i]) begin
      dispatch_valid = tbl[i].dv;
      dest_idx = tbl[i].idx;
      free_valid = tbl[i].fv;
      free_tag = tbl[i].tag;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(dispatch_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_wen", i), 32'(mt_write_en), 32'(tbl[i].wen));
      chk($sformatf("v%0d_pop", i), 32'(free_pop), 32'(tbl[i].pop));
      if (tbl[i].wen) begin
        chk($sformatf("v%0d_widx", i), 32'(mt_write_idx), 32'(tbl[i].widx));
        chk($sformatf("v%0d_wtag", i), 32'(mt_write_tag), 32'(tbl[i].wtag));
      end
      step();
    end

    // rollback together with dispatch, then a full walk
    dispatch_valid = 1'b1;
    dest_idx = 5'd3;
    free_valid = 1'b1;
    free_tag = 7'd50;
    rollback = 1'b1;
    #1;
    chk("rb_sq_rdy", 32'(dispatch_ready), 0);
    chk("rb_sq_wen", 32'(mt_write_en), 0);
    chk("rb_sq_pop", 32'(free_pop), 0);
    step();
    rollback = 1'b0;
    #1;
    for (int k = START; k < N; k++) begin
      chk("walk_busy", 32'(recover_busy), 1);
      chk("walk_wen", 32'(mt_write_en), 1);
      chk("walk_widx", 32'(mt_write_idx), 32'(k));
      chk("walk_wtag", 32'(mt_write_tag), 32'(k + 64));
      chk("walk_ard", 32'(arch_read_idx), 32'(k));
      chk("walk_rdy", 32'(dispatch_ready), 0);
      chk("walk_pop", 32'(free_pop), 0);
      chk("walk_done", 32'(recover_done), 0);
      step();
    end
    chk("done_pulse", 32'(recover_done), 1);
    chk("done_busy", 32'(recover_busy), 0);
    chk("done_wen", 32'(mt_write_en), 0);
    chk("done_rdy", 32'(dispatch_ready), 0);
    chk("done_ard", 32'(arch_read_idx), 0);
    step();
    chk("post_rdy", 32'(dispatch_ready), 1);
    chk("post_done", 32'(recover_done), 0);
    chk("post_wen", 32'(mt_write_en), 1);
    dispatch_valid = 1'b0;
    step();

    // second rollback mid-walk at cnt 12
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    #1;
    for (int k = START; k < 12; k++) step();
    chk("rb2_at12", 32'(mt_write_idx), 12);
    rollback = 1'b1;
    #1;
    chk("rb2_nodone", 32'(recover_done), 0);
    step();
    rollback = 1'b0;
    #1;
    chk("rb2_restart", 32'(mt_write_idx), 32'(START));
    busy_cyc = 0;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (recover_busy) busy_cyc++;
      if (recover_done) dones++;
      step();
    end
    chk("rb2_busy_cyc", 32'(busy_cyc), 32'(N - START));
    chk("rb2_dones", 32'(dones), 1);

    // reset mid-walk at cnt 7
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    #1;
    for (int k = START; k < 7; k++) step();
    chk("rst7_idx", 32'(mt_write_idx), 7);
    reset = 1'b1;
    dispatch_valid = 1'b1;
    #1;
    chk_zero("rst7_in");
    step();
    reset = 1'b0;
    #1;
    chk("rst7_idle_busy", 32'(recover_busy), 0);
    chk("rst7_idle_rdy", 32'(dispatch_ready), 1);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (recover_done || recover_busy) dones++;
      step();
    end
    chk("rst7_no_done", 32'(dones), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
